endat_pos_check: RTL and testbench

ENDAT_POS_CHECK -- requirements
Module: endat_pos_check

---
 rtl/endat_pos_check.sv | 127 ++++++++++++
 tb/tb_endat_pos_check.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/endat_pos_check.sv
// endat_pos_check: bit-serial CRC check of EnDat position frames with modular delta output,
// error counting, consecutive-error fault latch and overrun detection.
module endat_pos_check #(
  parameter int POS_W   = 19,
  parameter int ERR_LIM = 4
) (
  input  logic              enc_clk,
  input  logic              rst_n,
  input  logic              enc_valid,
  input  logic [25:0]       enc_pos,
  input  logic [4:0]        crc,
  input  logic              fault_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [25:0]       out_pos,
  output logic [POS_W:0]    out_delta,
  output logic              out_first,
  output logic              crc_err,
  output logic              overrun,
  output logic              fault,
  output logic [15:0]       err_cnt
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;
  localparam logic [4:0] LAST_BIT = 5'(POS_W - 1);
  localparam logic [3:0] LIM      = 4'(ERR_LIM);

  logic [1:0]       r_state;
  logic             r_vld, r_vld_d, r_arm;
  logic [POS_W-1:0] r_pos, r_prev;
  logic [4:0]       r_crc_rx, r_crc, r_cnt;
  logic [3:0]       r_consec;

  logic             w_edge, w_fb, w_match, w_lim_hit;
  logic [4:0]       w_crc_nx;
  logic [POS_W-1:0] w_diff;
  logic [3:0]       w_consec_nx;
  logic [25:0]      w_pos_ext;

  always_comb begin
    w_edge      = r_vld & ~r_vld_d;
    w_fb        = r_crc[4] ^ r_pos[r_cnt];
    w_crc_nx    = {r_crc[3:0], 1'b0} ^ (w_fb ? 5'b01011 : 5'b00000);
    w_match     = (~r_crc == r_crc_rx);
    w_diff      = r_pos - r_prev;
    w_consec_nx = (r_consec == LIM) ? LIM : r_consec + 4'd1;
    w_lim_hit   = (w_consec_nx == LIM);
    w_pos_ext   = '0;
    w_pos_ext[POS_W-1:0] = r_pos;
  end

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vld     <= 1'b0;
      r_vld_d   <= 1'b0;
      r_arm     <= 1'b1;
      r_pos     <= '0;
      r_prev    <= '0;
      r_crc_rx  <= '0;
      r_crc     <= '0;
      r_cnt     <= '0;
      r_consec  <= '0;
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_delta <= '0;
      out_first <= 1'b1;
      crc_err   <= 1'b0;
      overrun   <= 1'b0;
      fault     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      r_vld   <= enc_valid;
      r_vld_d <= r_vld;
      crc_err <= 1'b0;
      if (fault_clr) begin
        fault    <= 1'b0;
        overrun  <= 1'b0;
        r_consec <= '0;
        r_arm    <= 1'b1;
      end
      if (w_edge && r_state != S_IDLE) overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (w_edge) begin
          r_pos    <= enc_pos[POS_W-1:0];
          r_crc_rx <= crc;
          r_crc    <= 5'b11111;
          r_cnt    <= '0;
          r_state  <= S_CALC;
        end
        S_CALC: begin
          r_crc <= w_crc_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_BIT) r_state <= S_CHECK;
        end
        S_CHECK: if (!w_match) begin
          // a mismatch coincident with fault_clr still counts toward the fault
          crc_err  <= 1'b1;
          err_cnt  <= err_cnt + 16'(err_cnt != 16'hFFFF);
          r_consec <= w_consec_nx;
          if (w_lim_hit) fault <= 1'b1;
          r_state  <= S_IDLE;
        end else begin
          r_consec <= '0;
          r_prev   <= r_pos;
          if (fault) begin
            r_arm   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            out_valid <= 1'b1;
            out_pos   <= w_pos_ext;
            out_first <= r_arm;
            out_delta <= r_arm ? '0 : {w_diff[POS_W-1], w_diff};
            r_arm     <= 1'b0;
            r_state   <= S_OUT;
          end
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_endat_pos_check.sv
// tb_endat_pos_check: directed and randomized frames checked against a polynomial-division CRC
// and arithmetic delta model.
module tb_endat_pos_check;
  logic        clk = 1'b0;
  logic        rst_n, enc_valid, fault_clr, out_ready;
  logic [25:0] enc_pos;
  logic [4:0]  crc_in;
  logic        out_valid, out_first, crc_err, overrun, fault;
  logic [25:0] out_pos;
  logic [19:0] out_delta;
  logic [15:0] err_cnt;

  int n_chk = 0, n_fail = 0;
  int m_prev, m_consec, m_err;
  bit m_arm, m_fault, m_ovr;

  endat_pos_check #(.POS_W(19), .ERR_LIM(4)) dut (
    .enc_clk(clk), .rst_n(rst_n), .enc_valid(enc_valid), .enc_pos(enc_pos), .crc(crc_in),
    .fault_clr(fault_clr), .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
    .out_delta(out_delta), .out_first(out_first), .crc_err(crc_err), .overrun(overrun),
    .fault(fault), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC as remainder of (init*x^N + M(x)*x^5) mod x^5+x^3+x+1, first-sent bit highest degree
  function automatic logic [4:0] crc_of(input logic [18:0] p);
    logic [63:0] v;
    logic [18:0] m;
    for (int i = 0; i < 19; i++) m[18-i] = p[i];
    v = (64'(5'h1F) << 19) ^ (64'(m) << 5);
    for (int i = 63; i >= 5; i--) if (v[i]) v[i-:6] = v[i-:6] ^ 6'b101011;
    return ~v[4:0];
  endfunction

  function automatic int delta_of(input int p, input int q);
    int d;
    d = (p - q) & 32'h7FFFF;
    if (d >= 32'h40000) d = d - 32'h80000;
    return d;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_consec = 0; m_err = 0; m_arm = 1; m_fault = 0; m_ovr = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    m_fault = 0; m_ovr = 0; m_consec = 0; m_arm = 1;
    chk("clr_fault", fault, 0);
    chk("clr_overrun", overrun, 0);
  endtask

  task automatic run_frame(input logic [18:0] pos, input int flip);
    logic [4:0]  c;
    logic [19:0] d;
    c = crc_of(pos);
    if (flip >= 0) c[flip] = ~c[flip];
    d = 20'(delta_of(int'(pos), m_prev));
    @(negedge clk);
    enc_pos = {7'($urandom), pos}; crc_in = c; enc_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (k == 3) enc_valid = 1'b0;
      if (k == 20) chk("pre_valid", out_valid, 0);
      if (k == 21) begin
        if (flip >= 0) begin
          chk("crc_err_pulse", crc_err, 1);
          chk("bad_no_valid", out_valid, 0);
          m_err = (m_err < 65535) ? m_err + 1 : m_err;
          m_consec = (m_consec < 4) ? m_consec + 1 : 4;
          if (m_consec == 4) m_fault = 1;
        end else if (m_fault) begin
          chk("fault_no_valid", out_valid, 0);
          chk("fault_no_err", crc_err, 0);
          m_prev = int'(pos); m_arm = 1; m_consec = 0;
        end else begin
          chk("out_valid", out_valid, 1);
          chk("out_pos", out_pos, {7'b0, pos});
          chk("out_first", out_first, m_arm);
          chk("out_delta", out_delta, m_arm ? 20'd0 : d);
          chk("good_no_err", crc_err, 0);
          m_prev = int'(pos); m_arm = 0; m_consec = 0;
        end
      end
      if (k == 22) begin
        chk("valid_drop", out_valid, 0);
        chk("crc_err_end", crc_err, 0);
      end
    end
    chk("err_cnt", err_cnt, 32'(m_err));
    chk("fault", fault, m_fault);
    chk("overrun", overrun, m_ovr);
  endtask

  initial begin
    int n;
    logic [18:0] p1;
    rst_n = 1'b0; enc_valid = 1'b0; enc_pos = '0; crc_in = '0; fault_clr = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_first", out_first, 1);
    chk("rst_pos", out_pos, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(19'h12345, -1);
    run_frame(19'h7FFFE, -1);
    run_frame(19'h00002, -1);
    chk("delta_plus4", out_delta, 20'h00004);
    run_frame(19'h7FFFE, -1);
    chk("delta_minus4", out_delta, 20'hFFFFC);

    // stalled consumer with an intervening frame
    p1 = 19'h2A5A5;
    @(negedge clk);
    out_ready = 1'b0; enc_pos = {7'h0, p1}; crc_in = crc_of(p1); enc_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      if (k == 3) enc_valid = 1'b0;
    end
    chk("stall_valid", out_valid, 1);
    chk("stall_delta", out_delta, 20'(delta_of(int'(p1), m_prev)));
    for (int j = 1; j <= 50; j++) begin
      @(posedge clk); #1;
      if (j == 5) begin enc_pos = 26'h0011111; crc_in = crc_of(19'h11111); enc_valid = 1'b1; end
      if (j == 8) enc_valid = 1'b0;
    end
    m_ovr = 1; m_prev = int'(p1); m_arm = 0;
    chk("stall_overrun", overrun, 1);
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_pos", out_pos, {7'h0, p1});
    out_ready = 1'b1;
    n = 0;
    for (int j = 0; j < 40; j++) begin
      if (out_valid) n++;
      @(posedge clk); #1;
    end
    chk("one_transfer", n, 1);

    for (int i = 0; i < 24; i++)
      run_frame(19'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);

    pulse_clr();
    for (int i = 0; i < 4; i++) run_frame(19'($urandom), 0);
    chk("fault_set", fault, 1);
    run_frame(19'h01234, -1);
    pulse_clr();
    run_frame(19'h05678, -1);
    chk("first_after_clr", out_first, 1);

    // reset during CALC bit 10
    @(negedge clk);
    enc_pos = 26'h0033333; crc_in = crc_of(19'h33333); enc_valid = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    model_reset();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_pos", out_pos, 0);
    chk("mid_rst_delta", out_delta, 0);
    chk("mid_rst_first", out_first, 1);
    chk("mid_rst_crc_err", crc_err, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    enc_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      if (out_valid || crc_err) n++;
    end
    chk("no_out_after_rst", n, 0);
    run_frame(19'h54321, -1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
